nested_loop_seq: RTL and testbench

- Parametrised successor to the single-level loop-count FSM.
- Sequences a two-level loop, i outer and j inner, with runtime bounds and a start handshake.
- Emits each (i, j) index pair on a valid/ready interface, then pulses done and raises a sticky finish flag.
- Drives iteration-indexed datapath blocks in the project datapath.

---
 rtl/nested_loop_seq.sv | 155 +++++++++++++++
 tb/tb_nested_loop_seq.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nested_loop_seq.sv
// nested_loop_seq: two-level (i outer, j inner) loop sequencer.
// Emits each (i, j) index pair on a valid/ready interface. At the end of a
// normal run it pulses done for one cycle and sets a sticky finish flag.
module nested_loop_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] outer_bound,
  input  logic [WIDTH-1:0] inner_bound,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [WIDTH-1:0] idx_i,
  output logic [WIDTH-1:0] idx_j,
  output logic             busy,
  output logic             done,
  output logic             finish,
  output logic [CW-1:0]    iter_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // The inner step is one bit wider than the index. A carry out of the index
  // width therefore compares as "past the bound" and never wraps to a small j.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] outerBound_q, outerBound_d;
  logic [WIDTH-1:0] innerBound_q, innerBound_d;
  logic [WIDTH-1:0] idxI_q, idxI_d;
  logic [WIDTH-1:0] idxJ_q, idxJ_d;
  logic             idxValid_q, idxValid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             finish_q, finish_d;
  logic [CW-1:0]    iterCount_q, iterCount_d;

  logic [WIDTH:0]   jNext;
  logic [WIDTH-1:0] outerLast;

  assign jNext     = {1'b0, idxJ_q} + STEP_EXT;
  assign outerLast = outerBound_q - WIDTH'(1);

  // Next-state logic: accept a run in IDLE, step the index pair on each
  // handshake in RUN, and hold DONE for exactly one cycle.
  always_comb begin
    state_d      = state_q;
    outerBound_d = outerBound_q;
    innerBound_d = innerBound_q;
    idxI_d       = idxI_q;
    idxJ_d       = idxJ_q;
    idxValid_d   = idxValid_q;
    done_d       = 1'b0;
    finish_d     = finish_q;
    iterCount_d  = iterCount_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          outerBound_d = outer_bound;
          innerBound_d = inner_bound;
          idxI_d       = '0;
          idxJ_d       = '0;
          iterCount_d  = '0;
          finish_d     = 1'b0;
          if ((outer_bound == '0) || (inner_bound == '0)) begin
            state_d    = S_DONE;
            idxValid_d = 1'b0;
            done_d     = 1'b1;
            finish_d   = 1'b1;
          end else begin
            state_d    = S_RUN;
            idxValid_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d    = S_IDLE;
          idxValid_d = 1'b0;
        end else if (idx_ready) begin
          if (iterCount_q != '1) begin
            iterCount_d = iterCount_q + CW'(1);
          end
          if (jNext < {1'b0, innerBound_q}) begin
            idxJ_d = jNext[WIDTH-1:0];
          end else if (idxI_q == outerLast) begin
            state_d    = S_DONE;
            idxValid_d = 1'b0;
            done_d     = 1'b1;
            finish_d   = 1'b1;
          end else begin
            idxJ_d = '0;
            idxI_d = idxI_q + WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        state_d    = S_IDLE;
        idxValid_d = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        idxValid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset returns every output and both bound latches to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      outerBound_q <= '0;
      innerBound_q <= '0;
      idxI_q       <= '0;
      idxJ_q       <= '0;
      idxValid_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      finish_q     <= 1'b0;
      iterCount_q  <= '0;
    end else begin
      state_q      <= state_d;
      outerBound_q <= outerBound_d;
      innerBound_q <= innerBound_d;
      idxI_q       <= idxI_d;
      idxJ_q       <= idxJ_d;
      idxValid_q   <= idxValid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      finish_q     <= finish_d;
      iterCount_q  <= iterCount_d;
    end
  end

  assign idx_valid  = idxValid_q;
  assign idx_i      = idxI_q;
  assign idx_j      = idxJ_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign finish     = finish_q;
  assign iter_count = iterCount_q;

endmodule

// File: tb/tb_nested_loop_seq.sv
// tb_nested_loop_seq: directed checks of nested_loop_seq. One instance runs
// with STEP=1, one with STEP=3 and one with STEP=200.
module tb_nested_loop_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic [7:0] outerBound;
  logic [7:0] innerBound;
  logic       idxReady;
  logic       start1, start3, start200;

  logic        valid1, busy1, done1, finish1;
  logic [7:0]  i1, j1;
  logic [15:0] iter1;
  logic        valid3, busy3, done3, finish3;
  logic [7:0]  i3, j3;
  logic [15:0] iter3;
  logic        valid200, busy200, done200, finish200;
  logic [7:0]  i200, j200;
  logic [15:0] iter200;

  int total = 0;
  int bad   = 0;

  bit readySeq [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  int expJ4    [7] = '{1, 1, 1, 2, 2, 3, 3};
  int expIter4 [7] = '{1, 1, 1, 2, 2, 3, 4};

  nested_loop_seq #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .outer_bound(outerBound), .inner_bound(innerBound),
    .idx_valid(valid1), .idx_ready(idxReady), .idx_i(i1), .idx_j(j1),
    .busy(busy1), .done(done1), .finish(finish1), .iter_count(iter1));

  nested_loop_seq #(.WIDTH(8), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort),
    .outer_bound(outerBound), .inner_bound(innerBound),
    .idx_valid(valid3), .idx_ready(idxReady), .idx_i(i3), .idx_j(j3),
    .busy(busy3), .done(done3), .finish(finish3), .iter_count(iter3));

  nested_loop_seq #(.WIDTH(8), .STEP(200)) dut200 (
    .clk(clk), .rst(rst), .start(start200), .abort(abort),
    .outer_bound(outerBound), .inner_bound(innerBound),
    .idx_valid(valid200), .idx_ready(idxReady), .idx_i(i200), .idx_j(j200),
    .busy(busy200), .done(done200), .finish(finish200), .iter_count(iter200));

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] ob, input logic [7:0] ib, input logic rdy);
    outerBound = ob;
    innerBound = ib;
    idxReady   = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Directed sequence covering every entry in the test plan, in order.
  initial begin
    rst = 1'b1; abort = 1'b0; start1 = 1'b0; start3 = 1'b0; start200 = 1'b0;
    applyStimulus(8'd0, 8'd0, 1'b0);
    #1;
    checkOutput("rst_valid1", 32'(valid1), 32'd0);
    checkOutput("rst_busy1", 32'(busy1), 32'd0);
    checkOutput("rst_done1", 32'(done1), 32'd0);
    checkOutput("rst_finish1", 32'(finish1), 32'd0);
    checkOutput("rst_i1", 32'(i1), 32'd0);
    checkOutput("rst_j1", 32'(j1), 32'd0);
    checkOutput("rst_iter1", 32'(iter1), 32'd0);
    checkOutput("rst_all3", 32'({valid3, busy3, done3, finish3, i3, j3, iter3}), 32'd0);
    checkOutput("rst_all200", 32'({valid200, busy200, done200, finish200, i200, j200, iter200}), 32'd0);
    @(posedge clk); #3; rst = 1'b0;
    tick();
    checkOutput("idle_busy1", 32'(busy1), 32'd0);

    $display("[TB] test 1: 2x3 STEP=1");
    applyStimulus(8'd2, 8'd3, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("t1_valid0", 32'(valid1), 32'd1);
    checkOutput("t1_busy0", 32'(busy1), 32'd1);
    checkOutput("t1_i0", 32'(i1), 32'd0);
    checkOutput("t1_j0", 32'(j1), 32'd0);
    for (int k = 1; k < 6; k++) begin
      tick();
      checkOutput("t1_valid", 32'(valid1), 32'd1);
      checkOutput("t1_i", 32'(i1), 32'(k / 3));
      checkOutput("t1_j", 32'(j1), 32'(k % 3));
      checkOutput("t1_done_low", 32'(done1), 32'd0);
    end
    tick();
    checkOutput("t1_done", 32'(done1), 32'd1);
    checkOutput("t1_valid_end", 32'(valid1), 32'd0);
    checkOutput("t1_finish", 32'(finish1), 32'd1);
    checkOutput("t1_iter", 32'(iter1), 32'd6);
    checkOutput("t1_i_kept", 32'(i1), 32'd1);
    checkOutput("t1_j_kept", 32'(j1), 32'd2);
    tick();
    checkOutput("t1_done_pulse", 32'(done1), 32'd0);
    checkOutput("t1_busy_end", 32'(busy1), 32'd0);
    checkOutput("t1_finish_sticky", 32'(finish1), 32'd1);

    $display("[TB] test 2: zero bounds");
    applyStimulus(8'd0, 8'd5, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("t2a_done", 32'(done1), 32'd1);
    checkOutput("t2a_valid", 32'(valid1), 32'd0);
    checkOutput("t2a_iter", 32'(iter1), 32'd0);
    checkOutput("t2a_finish", 32'(finish1), 32'd1);
    tick();
    checkOutput("t2a_done_pulse", 32'(done1), 32'd0);
    applyStimulus(8'd3, 8'd0, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("t2b_done", 32'(done1), 32'd1);
    checkOutput("t2b_valid", 32'(valid1), 32'd0);
    checkOutput("t2b_iter", 32'(iter1), 32'd0);
    tick();
    checkOutput("t2b_busy", 32'(busy1), 32'd0);

    $display("[TB] test 3: STEP=3 inner=250, STEP=200 inner=255");
    applyStimulus(8'd1, 8'd250, 1'b1);
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    checkOutput("t3_j0", 32'(j3), 32'd0);
    for (int k = 1; k < 84; k++) begin
      tick();
      checkOutput("t3_j", 32'(j3), 32'(3 * k));
    end
    checkOutput("t3_i", 32'(i3), 32'd0);
    checkOutput("t3_valid_last", 32'(valid3), 32'd1);
    tick();
    checkOutput("t3_done", 32'(done3), 32'd1);
    checkOutput("t3_valid_end", 32'(valid3), 32'd0);
    checkOutput("t3_iter", 32'(iter3), 32'd84);
    checkOutput("t3_finish", 32'(finish3), 32'd1);
    tick();
    checkOutput("t3_busy_end", 32'(busy3), 32'd0);

    applyStimulus(8'd1, 8'd255, 1'b1);
    start200 = 1'b1;
    tick();
    start200 = 1'b0;
    checkOutput("t3b_j0", 32'(j200), 32'd0);
    checkOutput("t3b_valid0", 32'(valid200), 32'd1);
    tick();
    checkOutput("t3b_j1", 32'(j200), 32'd200);
    checkOutput("t3b_i1", 32'(i200), 32'd0);
    tick();
    checkOutput("t3b_done", 32'(done200), 32'd1);
    checkOutput("t3b_iter", 32'(iter200), 32'd2);
    checkOutput("t3b_finish", 32'(finish200), 32'd1);
    tick();
    checkOutput("t3b_busy_end", 32'(busy200), 32'd0);

    $display("[TB] test 4: ready backpressure");
    applyStimulus(8'd1, 8'd4, 1'b0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checkOutput("t4_j0", 32'(j1), 32'd0);
    for (int k = 0; k < 7; k++) begin
      idxReady = readySeq[k];
      tick();
      checkOutput("t4_j", 32'(j1), 32'(expJ4[k]));
      checkOutput("t4_iter", 32'(iter1), 32'(expIter4[k]));
      checkOutput("t4_done", 32'(done1), (k == 6) ? 32'd1 : 32'd0);
      checkOutput("t4_valid", 32'(valid1), (k == 6) ? 32'd0 : 32'd1);
    end
    tick();

    $display("[TB] test 5: abort");
    applyStimulus(8'd2, 8'd3, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    checkOutput("t5_iter_pre", 32'(iter1), 32'd2);
    checkOutput("t5_j_pre", 32'(j1), 32'd2);
    abort = 1'b1;
    tick();
    checkOutput("t5_busy", 32'(busy1), 32'd0);
    checkOutput("t5_valid", 32'(valid1), 32'd0);
    checkOutput("t5_done", 32'(done1), 32'd0);
    checkOutput("t5_finish", 32'(finish1), 32'd0);
    checkOutput("t5_iter", 32'(iter1), 32'd2);
    start1 = 1'b1;
    tick();
    checkOutput("t5_abort_start_busy", 32'(busy1), 32'd0);
    checkOutput("t5_abort_start_iter", 32'(iter1), 32'd2);
    start1 = 1'b0;
    abort  = 1'b0;
    tick();

    $display("[TB] test 6: async reset, start while busy");
    applyStimulus(8'd2, 8'd3, 1'b1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    checkOutput("t6_pre_iter", 32'(iter1), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(valid1), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy1), 32'd0);
    checkOutput("t6_rst_j", 32'(j1), 32'd0);
    checkOutput("t6_rst_iter", 32'(iter1), 32'd0);
    #2 rst = 1'b0;
    tick();
    applyStimulus(8'd1, 8'd2, 1'b1);
    start1 = 1'b1;
    tick();
    applyStimulus(8'd3, 8'd3, 1'b1);
    tick();
    checkOutput("t6_busy_j", 32'(j1), 32'd1);
    tick();
    start1 = 1'b0;
    checkOutput("t6_done", 32'(done1), 32'd1);
    checkOutput("t6_iter", 32'(iter1), 32'd2);
    checkOutput("t6_i", 32'(i1), 32'd0);
    tick();
    checkOutput("t6_idle", 32'(busy1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
